// File: rtl/fp32_mult_pipe.sv
// IEEE-754 binary32 multiplier: registered inputs, then classify, multiply, normalize, round/pack.
// Valid-only AXI-Stream operand/result channels; result appears 4 edges after issue.
module fp32_mult_pipe #(
  parameter int LATENCY_FIXED = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axis_a_tvalid,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  input  logic [31:0] s_axis_b_tdata,
  output logic        m_axis_result_tvalid,
  output logic [31:0] m_axis_result_tdata,
  output logic [2:0]  m_axis_result_tuser
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  if (LATENCY_FIXED != 4) begin : g_latency_check
    $error("fp32_mult_pipe has a fixed 4-cycle latency");
  end

  logic               v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [31:0]        a0_q, a0_d, b0_q, b0_d;
  logic               sign1_q, sign1_d, sign2_q, sign2_d, sign3_q, sign3_d;
  logic [7:0]         ea1_q, ea1_d, eb1_q, eb1_d;
  logic [22:0]        ma1_q, ma1_d, mb1_q, mb1_d;
  logic               spec1_q, spec1_d, spec2_q, spec2_d, spec3_q, spec3_d;
  logic [31:0]        spec_data1_q, spec_data1_d, spec_data2_q, spec_data2_d, spec_data3_q, spec_data3_d;
  logic [2:0]         spec_flags1_q, spec_flags1_d, spec_flags2_q, spec_flags2_d, spec_flags3_q, spec_flags3_d;
  logic signed [9:0]  exp2_q, exp2_d, exp3_q, exp3_d;
  logic [47:0]        prod2_q, prod2_d;
  logic [22:0]        frac3_q, frac3_d;
  logic               guard3_q, guard3_d, sticky3_q, sticky3_d;
  logic               tvalid_q, tvalid_d;
  logic [31:0]        tdata_q, tdata_d;
  logic [2:0]         tuser_q, tuser_d;

  // Stage 0: register the raw operands; an op issues only when both channels are valid.
  always_comb begin
    v0_d = s_axis_a_tvalid & s_axis_b_tvalid;
    a0_d = s_axis_a_tdata;
    b0_d = s_axis_b_tdata;
  end

  // Stage 1: unpack and classify. Subnormals collapse to zero.
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic        za, zb, ia, ib, na, nb, s;
  always_comb begin
    ea = a0_q[30:23];
    eb = b0_q[30:23];
    ma = a0_q[22:0];
    mb = b0_q[22:0];
    s  = a0_q[31] ^ b0_q[31];
    za = (ea == 8'd0);
    zb = (eb == 8'd0);
    ia = (ea == 8'hFF) && (ma == 23'd0);
    ib = (eb == 8'hFF) && (mb == 23'd0);
    na = (ea == 8'hFF) && (ma != 23'd0);
    nb = (eb == 8'hFF) && (mb != 23'd0);
    v1_d          = v0_q;
    sign1_d       = s;
    ea1_d         = ea;
    eb1_d         = eb;
    ma1_d         = ma;
    mb1_d         = mb;
    spec1_d       = za | zb | ia | ib | na | nb;
    spec_flags1_d = 3'b000;
    if (na | nb) begin
      spec_data1_d = QNAN;
    end else if ((ia & zb) | (za & ib)) begin
      spec_data1_d  = QNAN;
      spec_flags1_d = 3'b100;
    end else if (ia | ib) begin
      spec_data1_d = {s, 8'hFF, 23'd0};
    end else begin
      spec_data1_d = {s, 31'd0};
    end
  end

  // Stage 2: exponent sum and full 24x24 significand product.
  always_comb begin
    v2_d          = v1_q;
    sign2_d       = sign1_q;
    exp2_d        = $signed({2'b00, ea1_q}) + $signed({2'b00, eb1_q}) - 10'sd127;
    prod2_d       = 48'({1'b1, ma1_q}) * 48'({1'b1, mb1_q});
    spec2_d       = spec1_q;
    spec_data2_d  = spec_data1_q;
    spec_flags2_d = spec_flags1_q;
  end

  // Stage 3: normalize to [1,2); the hidden bit is dropped here since it is always 1.
  always_comb begin
    v3_d          = v2_q;
    sign3_d       = sign2_q;
    spec3_d       = spec2_q;
    spec_data3_d  = spec_data2_q;
    spec_flags3_d = spec_flags2_q;
    if (prod2_q[47]) begin
      exp3_d    = exp2_q + 10'sd1;
      frac3_d   = prod2_q[46:24];
      guard3_d  = prod2_q[23];
      sticky3_d = |prod2_q[22:0];
    end else begin
      exp3_d    = exp2_q;
      frac3_d   = prod2_q[45:23];
      guard3_d  = prod2_q[22];
      sticky3_d = |prod2_q[21:0];
    end
  end

  // Stage 4: round to nearest even, range check, pack. Data holds while idle; flags clear.
  logic              inc;
  logic [23:0]       frac_rnd;
  logic signed [9:0] exp_r;
  always_comb begin
    inc      = guard3_q & (sticky3_q | frac3_q[0]);
    frac_rnd = {1'b0, frac3_q} + {23'd0, inc};
    exp_r    = frac_rnd[23] ? (exp3_q + 10'sd1) : exp3_q;
    tvalid_d = v3_q;
    tdata_d  = tdata_q;
    tuser_d  = 3'b000;
    if (v3_q) begin
      if (spec3_q) begin
        tdata_d = spec_data3_q;
        tuser_d = spec_flags3_q;
      end else if (exp_r >= 10'sd255) begin
        tdata_d = {sign3_q, 8'hFF, 23'd0};
        tuser_d = 3'b010;
      end else if (exp_r <= 10'sd0) begin
        tdata_d = {sign3_q, 31'd0};
        tuser_d = 3'b001;
      end else begin
        tdata_d = {sign3_q, exp_r[7:0], frac_rnd[22:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= 32'd0;
      tuser_q  <= 3'b000;
    end else begin
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
    end
  end

  // Datapath registers carry no reset so the product register can pack into a DSP.
  always_ff @(posedge clk) begin
    a0_q          <= a0_d;
    b0_q          <= b0_d;
    sign1_q       <= sign1_d;
    ea1_q         <= ea1_d;
    eb1_q         <= eb1_d;
    ma1_q         <= ma1_d;
    mb1_q         <= mb1_d;
    spec1_q       <= spec1_d;
    spec_data1_q  <= spec_data1_d;
    spec_flags1_q <= spec_flags1_d;
    sign2_q       <= sign2_d;
    exp2_q        <= exp2_d;
    prod2_q       <= prod2_d;
    spec2_q       <= spec2_d;
    spec_data2_q  <= spec_data2_d;
    spec_flags2_q <= spec_flags2_d;
    sign3_q       <= sign3_d;
    exp3_q        <= exp3_d;
    frac3_q       <= frac3_d;
    guard3_q      <= guard3_d;
    sticky3_q     <= sticky3_d;
    spec3_q       <= spec3_d;
    spec_data3_q  <= spec_data3_d;
    spec_flags3_q <= spec_flags3_d;
  end

  assign m_axis_result_tvalid = tvalid_q;
  assign m_axis_result_tdata  = tdata_q;
  assign m_axis_result_tuser  = tuser_q;

endmodule

// File: tb/tb_fp32_mult_pipe.sv
// Directed bench for fp32_mult_pipe: expected products are queued at issue time
// with the cycle they are due, and matched as results emerge.
module tb_fp32_mult_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_tvalid, b_tvalid;
  logic [31:0] a_tdata, b_tdata;
  logic        r_tvalid;
  logic [31:0] r_tdata;
  logic [2:0]  r_tuser;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [2:0]  user;
    int          due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fp32_mult_pipe #(.LATENCY_FIXED(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .s_axis_a_tvalid      (a_tvalid),
    .s_axis_a_tdata       (a_tdata),
    .s_axis_b_tvalid      (b_tvalid),
    .s_axis_b_tdata       (b_tdata),
    .m_axis_result_tvalid (r_tvalid),
    .m_axis_result_tdata  (r_tdata),
    .m_axis_result_tuser  (r_tuser)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One stimulus slot: inputs change 1 time unit after an edge and are sampled at the next edge.
  task automatic drive(input logic rst, input logic av, input logic [31:0] a,
                       input logic bv, input logic [31:0] b);
    @(posedge clk);
    #1;
    reset    = rst;
    a_tvalid = av;
    a_tdata  = a;
    b_tvalid = bv;
    b_tdata  = b;
  endtask

  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic [2:0] eu);
    exp_t e;
    drive(1'b0, 1'b1, a, 1'b1, b);
    e.tag  = tag;
    e.data = ed;
    e.user = eu;
    e.due  = cyc + 5;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: every output is matched against the queue head; a due entry with no tvalid is a miss.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (r_tvalid === 1'b1) begin
        if (sb.size() == 0) begin
          check32("unexpected_tvalid", {31'd0, r_tvalid}, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("cycle %0d %s: tdata=%h tuser=%b (expected %h %b due %0d)",
                   cyc, e.tag, r_tdata, r_tuser, e.data, e.user, e.due);
          check32({e.tag, "_data"}, r_tdata, e.data);
          check32({e.tag, "_user"}, {29'd0, r_tuser}, {29'd0, e.user});
          check32({e.tag, "_cycle"}, cyc, e.due);
        end
      end else begin
        check32("idle_tuser", {29'd0, r_tuser}, 32'd0);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          check32({e.tag, "_missing_tvalid"}, {31'd0, r_tvalid}, 32'd1);
        end
      end
    end
  end

  initial begin
    logic [31:0] ops[8];
    logic [31:0] prods[8];
    ops   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    prods = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
              32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

    reset    = 1'b1;
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    a_tdata  = 32'h0;
    b_tdata  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check32("reset_tvalid", {31'd0, r_tvalid}, 32'd0);
    check32("reset_tdata", r_tdata, 32'd0);
    check32("reset_tuser", {29'd0, r_tuser}, 32'd0);
    reset = 1'b0;
    idle(2);

    // Basic product, then quiet cycles around it
    issue("basic_2x3", 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
    idle(7);

    // Rounding and sign handling
    issue("tie_even", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000);
    issue("1p5_sq", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000);
    issue("neg_2x3", 32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000);
    issue("near_two", 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000);
    issue("round_to_2", 32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 3'b000);
    idle(6);

    // Exceptions and special operands
    issue("overflow", 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 3'b010);
    issue("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 3'b001);
    issue("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100);
    issue("ninf_x_2", 32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);
    issue("nan_x_1", 32'h7FC12345, 32'h3F800000, 32'h7FC00000, 3'b000);
    issue("nzero_x_2", 32'h80000000, 32'h40000000, 32'h80000000, 3'b000);
    issue("subnorm_x_2", 32'h00000001, 32'h40000000, 32'h00000000, 3'b000);
    idle(6);

    // Back-to-back stream
    for (int k = 0; k < 8; k++) begin
      issue($sformatf("stream%0d", k), ops[k], 32'h40000000, prods[k], 3'b000);
    end
    idle(6);

    // Only one channel valid: nothing may come out
    drive(1'b0, 1'b1, 32'h40000000, 1'b0, 32'h40400000);
    idle(11);

    // Reset while three pairs are in flight; none of them may surface
    drive(1'b0, 1'b1, 32'h3F800000, 1'b1, 32'h3F800000);
    drive(1'b0, 1'b1, 32'h40000000, 1'b1, 32'h40000000);
    drive(1'b1, 1'b1, 32'h40400000, 1'b1, 32'h40400000);
    issue("after_reset", 32'h40400000, 32'h40800000, 32'h41400000, 3'b000);
    idle(8);

    check32("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
